// File: rtl/pwm_burst_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_burst_sequencer
//
// Purpose:
//   Multi-phase PWM burst generator. A small configuration table holds, for
//   each phase, the PWM period, the duty (high clocks) and how many PWM cycles
//   the phase lasts. The sequencer walks through the phases in order and
//   wraps back to phase 0. Starting from IDLE it first ramps the duty through
//   a soft-start of 2^SS_SHIFT PWM cycles, then runs at full duty. A
//   synchronised fault input forces the output low at once and parks the
//   block in FAULT until it is explicitly cleared.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   enable     - run request (level)
//   fault_in   - asynchronous fault request, active-high
//   fault_clr  - single-cycle fault-clear pulse
//   cfg_we     - configuration write strobe
//   cfg_addr   - phase index to write
//   cfg_sel    - field select: 0=period_m1, 1=duty, 2=pulses, 3=ignored
//   cfg_data   - write data (low PULSE_W bits used for pulses)
//   pwm_out    - registered PWM output
//   phase_idx  - active phase
//   state_out  - 0=IDLE, 1=SOFTSTART, 2=RUN, 3=FAULT
//   cycle_tick - high on the last clock of every PWM cycle
// -----------------------------------------------------------------------------
module pwm_burst_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 24,
    parameter int PULSE_W    = 8,
    parameter int SS_SHIFT   = 4,
    localparam int PH_W      = $clog2(NUM_PHASES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fault_in,
    input  logic             fault_clr,
    input  logic             cfg_we,
    input  logic [PH_W-1:0]  cfg_addr,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
    output logic             pwm_out,
    output logic [PH_W-1:0]  phase_idx,
    output logic [1:0]       state_out,
    output logic             cycle_tick
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SOFTSTART = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } state_e;

    localparam logic [SS_SHIFT-1:0] SS_LAST = {SS_SHIFT{1'b1}};

    state_e               state_q, state_d;
    logic                 faultMeta_q, faultSync_q;
    logic [CNT_W-1:0]     periodTab_q [NUM_PHASES];
    logic [CNT_W-1:0]     dutyTab_q   [NUM_PHASES];
    logic [PULSE_W-1:0]   pulsesTab_q [NUM_PHASES];
    logic [CNT_W-1:0]     actPeriod_q, actDuty_q;
    logic [CNT_W-1:0]     periodCnt_q, periodCnt_d;
    logic [PULSE_W-1:0]   pulseCnt_q, pulseCnt_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [SS_SHIFT-1:0]  ssStep_q, ssStep_d;
    logic                 pwm_q, pwm_d;

    logic [CNT_W-1:0]          curPeriod, curDuty, effDuty;
    logic [CNT_W+SS_SHIFT-1:0] ssProduct;
    logic [PULSE_W-1:0]        lastPulse;
    logic                      running, cycleTick;

    // Two-flop synchroniser on the asynchronous fault request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            faultMeta_q <= 1'b0;
            faultSync_q <= 1'b0;
        end else begin
            faultMeta_q <= fault_in;
            faultSync_q <= faultMeta_q;
        end
    end

    // Configuration table; writes land on the next edge in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                periodTab_q[i] <= CNT_W'(99);
                dutyTab_q[i]   <= CNT_W'(50);
                pulsesTab_q[i] <= PULSE_W'(1);
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (cfg_addr == PH_W'(i)) begin
                    case (cfg_sel)
                        2'd0:    periodTab_q[i] <= cfg_data;
                        2'd1:    dutyTab_q[i]   <= cfg_data;
                        2'd2:    pulsesTab_q[i] <= cfg_data[PULSE_W-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Snapshot period and duty while the period counter sits at 0, so a
    // table write in the middle of a cycle only affects the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            actPeriod_q <= '0;
            actDuty_q   <= '0;
        end else if (periodCnt_q == '0) begin
            actPeriod_q <= periodTab_q[phase_q];
            actDuty_q   <= dutyTab_q[phase_q];
        end
    end

    // Parameters in force this clock. At count 0 the snapshot is being taken,
    // so the table is read directly. Soft-start scales the duty by
    // (ss_step+1)/2^SS_SHIFT, formed as duty*ss_step + duty at full width.
    always_comb begin
        curPeriod = (periodCnt_q == '0) ? periodTab_q[phase_q] : actPeriod_q;
        curDuty   = (periodCnt_q == '0) ? dutyTab_q[phase_q]   : actDuty_q;
        ssProduct = (CNT_W+SS_SHIFT)'(curDuty) * (CNT_W+SS_SHIFT)'(ssStep_q)
                  + (CNT_W+SS_SHIFT)'(curDuty);
        effDuty   = (state_q == SOFTSTART) ? CNT_W'(ssProduct >> SS_SHIFT) : curDuty;
        running   = (state_q == SOFTSTART) || (state_q == RUN);
        cycleTick = running && (periodCnt_q == curPeriod);
        lastPulse = (pulsesTab_q[phase_q] == '0) ? '0 : pulsesTab_q[phase_q] - 1'b1;
    end

    // Next-state logic: PWM cycle counting, pulse/phase sequencing, soft-start
    // stepping, and the fault override which wins over everything else.
    always_comb begin
        state_d     = state_q;
        periodCnt_d = periodCnt_q;
        pulseCnt_d  = pulseCnt_q;
        phase_d     = phase_q;
        ssStep_d    = ssStep_q;
        pwm_d       = 1'b0;
        case (state_q)
            IDLE: begin
                periodCnt_d = '0;
                pulseCnt_d  = '0;
                phase_d     = '0;
                ssStep_d    = '0;
                if (enable) state_d = SOFTSTART;
            end
            SOFTSTART, RUN: begin
                pwm_d = (periodCnt_q < effDuty);
                if (cycleTick) begin
                    periodCnt_d = '0;
                    // >= guards against pulses being shrunk mid-phase.
                    if (pulseCnt_q >= lastPulse) begin
                        pulseCnt_d = '0;
                        phase_d    = (phase_q == PH_W'(NUM_PHASES-1)) ? '0 : phase_q + 1'b1;
                    end else begin
                        pulseCnt_d = pulseCnt_q + 1'b1;
                    end
                    if (state_q == SOFTSTART) begin
                        if (ssStep_q == SS_LAST) begin
                            ssStep_d = '0;
                            state_d  = RUN;
                        end else begin
                            ssStep_d = ssStep_q + 1'b1;
                        end
                    end
                    if (!enable) begin
                        state_d    = IDLE;
                        pulseCnt_d = '0;
                        phase_d    = '0;
                        ssStep_d   = '0;
                    end
                end else begin
                    periodCnt_d = periodCnt_q + 1'b1;
                end
            end
            default: begin
                periodCnt_d = '0;
                pulseCnt_d  = '0;
                phase_d     = '0;
                ssStep_d    = '0;
                if (fault_clr && !faultSync_q) state_d = enable ? SOFTSTART : IDLE;
            end
        endcase
        if (faultSync_q) begin
            state_d     = FAULT;
            periodCnt_d = '0;
            pulseCnt_d  = '0;
            phase_d     = '0;
            ssStep_d    = '0;
            pwm_d       = 1'b0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            periodCnt_q <= '0;
            pulseCnt_q  <= '0;
            phase_q     <= '0;
            ssStep_q    <= '0;
            pwm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            periodCnt_q <= periodCnt_d;
            pulseCnt_q  <= pulseCnt_d;
            phase_q     <= phase_d;
            ssStep_q    <= ssStep_d;
            pwm_q       <= pwm_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign phase_idx  = phase_q;
    assign state_out  = state_q;
    assign cycle_tick = cycleTick;

endmodule

// File: tb/tb_pwm_burst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pwm_burst_sequencer
//
// Directed bench for pwm_burst_sequencer with NUM_PHASES=2, CNT_W=8,
// PULSE_W=4, SS_SHIFT=2. PWM cycles are observed as windows of pwm_out
// samples, offset one clock from the period counter by the output register.
// -----------------------------------------------------------------------------
module tb_pwm_burst_sequencer;

    localparam int NP = 2;
    localparam int CW = 8;
    localparam int PW = 4;
    localparam int SS = 2;
    localparam int NWIN = 23;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        enable    = 1'b0;
    logic        fault_in  = 1'b0;
    logic        fault_clr = 1'b0;
    logic        cfg_we    = 1'b0;
    logic [0:0]  cfg_addr  = '0;
    logic [1:0]  cfg_sel   = '0;
    logic [7:0]  cfg_data  = '0;
    logic        pwm_out;
    logic [0:0]  phase_idx;
    logic [1:0]  state_out;
    logic        cycle_tick;

    int errors = 0;
    int checks = 0;

    // Expected PWM windows: length, high clocks, phase, state, duty written
    // to phase 0 during the window (-1 = no write).
    int wLen  [NWIN] = '{10,10,10,20, 20,10,10,10,20,20, 10,10,10,20,20, 10,10,10,20,20, 10,10,10};
    int wHigh [NWIN] = '{ 1, 2, 3,10, 10, 5, 5, 5,10,10,  5, 8, 8,10,10,  8, 0, 0,10,10,  0,10,10};
    int wPhase[NWIN] = '{ 0, 0, 0, 1,  1, 0, 0, 0, 1, 1,  0, 0, 0, 1, 1,  0, 0, 0, 1, 1,  0, 0, 0};
    int wState[NWIN] = '{ 1, 1, 1, 1,  2, 2, 2, 2, 2, 2,  2, 2, 2, 2, 2,  2, 2, 2, 2, 2,  2, 2, 2};
    int wData [NWIN] = '{-1,-1,-1,-1, -1,-1,-1,-1,-1,-1,  8,-1,-1,-1,-1,  0,-1,-1,-1,-1, 12,-1,-1};

    pwm_burst_sequencer #(
        .NUM_PHASES(NP),
        .CNT_W     (CW),
        .PULSE_W   (PW),
        .SS_SHIFT  (SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .fault_in  (fault_in),
        .fault_clr (fault_clr),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .pwm_out   (pwm_out),
        .phase_idx (phase_idx),
        .state_out (state_out),
        .cycle_tick(cycle_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks, landing 1 time unit after the edge; strobes and the
    // clear pulse only ever last one clock.
    task automatic stepClk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cfg_we    = 1'b0;
            fault_clr = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [0:0] addr, input logic [1:0] sel, input logic [7:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_sel  = sel;
        cfg_data = data;
        stepClk(1);
    endtask

    task automatic measureCycle(input int len, output int highs, output int ticks);
        highs = 0;
        ticks = 0;
        for (int i = 0; i < len; i++) begin
            highs += int'(pwm_out);
            ticks += int'(cycle_tick);
            stepClk(1);
        end
    endtask

    initial begin
        int highs;
        int ticks;

        $display("[TB] start");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_pwm",   pwm_out,    0);
        checkOutput("reset_state", state_out,  0);
        checkOutput("reset_phase", phase_idx,  0);
        checkOutput("reset_tick",  cycle_tick, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        stepClk(1);
        checkOutput("idle_after_reset", state_out, 0);

        applyStimulus(1'b0, 2'd0, 8'd9);
        applyStimulus(1'b0, 2'd1, 8'd5);
        applyStimulus(1'b0, 2'd2, 8'd3);
        applyStimulus(1'b1, 2'd0, 8'd19);
        applyStimulus(1'b1, 2'd1, 8'd10);
        applyStimulus(1'b1, 2'd2, 8'd2);

        enable = 1'b1;
        stepClk(1);
        checkOutput("ss_entry_state", state_out, 1);
        checkOutput("ss_entry_phase", phase_idx, 0);
        stepClk(1);

        // Soft-start ramp, RUN sequencing, mid-cycle duty writes, duty 0 and
        // duty above the period.
        for (int w = 0; w < NWIN; w++) begin
            checkOutput($sformatf("win%0d_phase", w), phase_idx, wPhase[w]);
            checkOutput($sformatf("win%0d_state", w), state_out, wState[w]);
            if (wData[w] >= 0) begin
                cfg_we   = 1'b1;
                cfg_addr = 1'b0;
                cfg_sel  = 2'd1;
                cfg_data = 8'(wData[w]);
            end
            measureCycle(wLen[w], highs, ticks);
            checkOutput($sformatf("win%0d_high", w), highs, wHigh[w]);
            checkOutput($sformatf("win%0d_ticks", w), ticks, 1);
        end

        // Fault in the middle of a phase-1 RUN cycle.
        stepClk(3);
        checkOutput("pre_fault_pwm", pwm_out, 1);
        fault_in = 1'b1;
        stepClk(2);
        checkOutput("fault_sync_delay", state_out, 2);
        stepClk(1);
        checkOutput("fault_state", state_out, 3);
        checkOutput("fault_pwm",   pwm_out,   0);
        checkOutput("fault_phase", phase_idx, 0);
        fault_clr = 1'b1;
        stepClk(1);
        checkOutput("clr_ignored", state_out, 3);
        fault_in = 1'b0;
        stepClk(3);
        checkOutput("fault_held", state_out, 3);
        checkOutput("fault_tick", cycle_tick, 0);
        fault_clr = 1'b1;
        stepClk(1);
        checkOutput("clr_state", state_out, 1);
        checkOutput("clr_phase", phase_idx, 0);
        checkOutput("clr_pwm",   pwm_out,   0);

        // Enable dropped mid-cycle: the phase-0 cycle finishes first.
        stepClk(3);
        enable = 1'b0;
        stepClk(6);
        checkOutput("drop_last_tick",  cycle_tick, 1);
        checkOutput("drop_last_state", state_out,  1);
        stepClk(1);
        checkOutput("drop_idle_state", state_out, 0);
        checkOutput("drop_idle_pwm",   pwm_out,   0);
        checkOutput("drop_idle_phase", phase_idx, 0);
        stepClk(2);
        checkOutput("idle_hold_pwm",   pwm_out,   0);
        checkOutput("idle_hold_state", state_out, 0);

        // Reset asserted mid-cycle while pwm_out is high.
        enable = 1'b1;
        stepClk(2);
        checkOutput("pre_reset_pwm", pwm_out, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_pwm",   pwm_out,    0);
        checkOutput("async_rst_state", state_out,  0);
        checkOutput("async_rst_phase", phase_idx,  0);
        checkOutput("async_rst_tick",  cycle_tick, 0);
        enable = 1'b0;
        stepClk(2);
        @(negedge clk) rst_n = 1'b1;
        stepClk(1);
        checkOutput("post_rst_idle", state_out, 0);

        // Table back at 99/50/1: first soft-start cycle gives 50*1>>2 = 12.
        enable = 1'b1;
        stepClk(1);
        checkOutput("post_rst_ss", state_out, 1);
        stepClk(1);
        measureCycle(100, highs, ticks);
        checkOutput("default_high",  highs, 12);
        checkOutput("default_ticks", ticks, 1);
        checkOutput("default_phase", phase_idx, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
